// File: rtl/cond_logic.sv
// ARM condition-check unit: holds the NZCV status register, evaluates the
// instruction condition field against it and gates the decoder write strobes.
module cond_logic #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  localparam int COND_W = 4;

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic [COND_W-1:0] cond_sel;
  logic n_flag, z_flag, c_flag, v_flag;
  logic cond_ex;

  assign cond_sel = Cond;
  assign {n_flag, z_flag} = nz_q;
  assign {c_flag, v_flag} = cv_q;

  // Condition is judged on flags left by earlier instructions, not ALUFlags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_sel)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[1] && cond_ex && !Stall) nz_d = ALUFlags[3:2];
    if (FlagW[0] && cond_ex && !Stall) cv_d = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q <= FLAG_RST[3:2];
      cv_q <= FLAG_RST[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  // Strobes are deliberately not stall-gated; that happens upstream.
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;
  assign Flags    = {nz_q, cv_q};

endmodule
